// File: rtl/fun_table_pkg.sv
// fun_table_pkg: digit encodings and threshold tables for the SRT radix-4 quotient-digit table.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
//
// Contents: Q_* digit encodings, T2_TAB/T1_TAB indexed by b[2:0], select_digit().
package fun_table_pkg;

   // Quotient digits, 3-bit two's complement
   localparam logic [2:0] Q_P2 = 3'b010;
   localparam logic [2:0] Q_P1 = 3'b001;
   localparam logic [2:0] Q_Z  = 3'b000;
   localparam logic [2:0] Q_M1 = 3'b111;
   localparam logic [2:0] Q_M2 = 3'b110;

   // Thresholds in raw p units (1/8). Element [i] serves divisor b = 8 + i.
   localparam logic [7:0][3:0] T2_TAB = {4'd11, 4'd10, 4'd10, 4'd9, 4'd8, 4'd8, 4'd7, 4'd6};
   localparam logic [7:0][3:0] T1_TAB = {4'd3,  4'd3,  4'd3,  4'd3, 4'd2, 4'd2, 4'd2, 4'd2};

   // Signed compare of the remainder estimate against +/-T2 and +/-T1.
   // Operands are widened to 7 bits so the negated thresholds never wrap.
   function automatic logic [2:0] select_digit(input logic [2:0] bidx, input logic [5:0] p);
      logic signed [6:0] pe;
      logic signed [6:0] t2;
      logic signed [6:0] t1;
      logic [2:0]        dig;
      pe = signed'({p[5], p});
      t2 = signed'({3'b000, T2_TAB[bidx]});
      t1 = signed'({3'b000, T1_TAB[bidx]});
      if (pe >= t2)
         dig = Q_P2;
      else if (pe >= t1)
         dig = Q_P1;
      else if (pe >= -t1)
         dig = Q_Z;
      else if (pe >= -t2)
         dig = Q_M1;
      else
         dig = Q_M2;
      return dig;
   endfunction

endpackage

// File: rtl/fun_table_if.sv
// fun_table_if: divisor/remainder-estimate inputs and quotient-digit output of the selection table.
// Latency: n/a (wires only).
// Backpressure: none; the table accepts a new b,p every cycle.
//
// Signals: b (4, divisor MSBs 1.bbb), p (6, signed remainder estimate, 3.3), q (3, signed digit).
// master drives b,p and consumes q; slave is the table.
interface fun_table_if;
   logic [3:0] b;
   logic [5:0] p;
   logic [2:0] q;

   modport master (output b, output p, input q);
   modport slave  (input b, input p, output q);
endinterface

// File: rtl/fun_table_lut.sv
// fun_table_lut: combinational b,p -> quotient digit lookup.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports: b_i (4) divisor MSBs, p_i (6) signed remainder estimate, digit_o (3) selected digit.
module fun_table_lut
   import fun_table_pkg::*;
(
   input  logic [3:0] b_i,
   input  logic [5:0] p_i,
   output logic [2:0] digit_o
);

   // Leading divisor bit is always 1 for a normalised divisor, so only b[2:0] indexes the table.
   logic unused_b_msb;
   assign unused_b_msb = b_i[3];

   always_comb begin
      digit_o = select_digit(b_i[2:0], p_i);
   end

endmodule

// File: rtl/fun_table.sv
// fun_table: registered SRT radix-4 quotient-digit selection (digit set -2..+2).
// Latency: 1 cycle from b,p sampled to q valid.
// Backpressure: none; new b,p accepted every cycle.
//
// Ports: clk (clock), rst (synchronous active-high reset, forces q=0),
//        tbl (fun_table_if.slave: b, p in; q out).
module fun_table
   import fun_table_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   fun_table_if.slave  tbl
);

   logic [2:0] digit;
   logic [2:0] q_d;
   logic [2:0] q_q;

   fun_table_lut u_lut (
      .b_i     (tbl.b),
      .p_i     (tbl.p),
      .digit_o (digit)
   );

   always_comb begin
      q_d = digit;
   end

   // Reset wins over the lookup on the same edge.
   always_ff @(posedge clk) begin
      if (rst)
         q_q <= Q_Z;
      else
         q_q <= q_d;
   end

   assign tbl.q = q_q;

endmodule

// File: tb/tb_fun_table.sv
// tb_fun_table: bench for the quotient-digit selection table.
// Latency: expects q one edge after b,p are applied.
// Backpressure: none; stimulus changes every cycle.
module tb_fun_table;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   fun_table_if intf ();

   fun_table dut (
      .clk (clk),
      .rst (rst),
      .tbl (intf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference thresholds for b = 8..15
   int t2_ref [8] = '{6, 7, 8, 8, 9, 10, 10, 11};
   int t1_ref [8] = '{2, 2, 2, 2, 3,  3,  3,  3};

   // Observed digits from the exhaustive sweep, for the symmetry check
   logic [2:0] obs [8][64];

   // Digit = number of thresholds (-T2, -T1, T1, T2) at or below p, minus 2.
   function automatic logic [2:0] ref_digit(input logic [3:0] b, input logic [5:0] p);
      int pv;
      int k;
      int d;
      k  = int'(b) % 8;
      pv = int'(p);
      if (pv >= 32) pv = pv - 64;
      d = -2;
      if (pv >= -t2_ref[k]) d++;
      if (pv >= -t1_ref[k]) d++;
      if (pv >=  t1_ref[k]) d++;
      if (pv >=  t2_ref[k]) d++;
      return 3'(d);
   endfunction

   task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: q=%b expected %b", tag, got, exp);
      end
   endtask

   // Drive one input set at the falling edge; return q sampled just after the next rising edge.
   task automatic apply(input logic r, input logic [3:0] b, input logic [5:0] p, output logic [2:0] q);
      @(negedge clk);
      rst    = r;
      intf.b = b;
      intf.p = p;
      @(posedge clk);
      #1;
      q = intf.q;
   endtask

   task automatic directed(input string tag, input logic [3:0] b, input int p, input logic [2:0] exp);
      logic [2:0] q;
      apply(1'b0, b, 6'(p), q);
      check(tag, q, exp);
      check({tag, "_model"}, q, ref_digit(b, 6'(p)));
   endtask

   initial begin
      logic [2:0] q;
      logic       r;
      logic [3:0] b;
      logic [5:0] p;
      n_checks = 0;
      n_errors = 0;
      rst    = 1'b1;
      intf.b = 4'd15;
      intf.p = 6'd31;

      // Reset holds q at zero even with a +2 input present
      apply(1'b1, 4'd15, 6'd31, q);
      check("rst_edge1", q, 3'b000);
      apply(1'b1, 4'd15, 6'd31, q);
      check("rst_edge2", q, 3'b000);
      apply(1'b0, 4'd15, 6'd31, q);
      check("rst_release", q, 3'b010);

      // b=8 threshold boundaries
      directed("b8_p6",  4'd8,  6, 3'b010);
      directed("b8_p5",  4'd8,  5, 3'b001);
      directed("b8_p2",  4'd8,  2, 3'b001);
      directed("b8_p1",  4'd8,  1, 3'b000);
      directed("b8_m2",  4'd8, -2, 3'b000);
      directed("b8_m3",  4'd8, -3, 3'b111);
      directed("b8_m6",  4'd8, -6, 3'b111);
      directed("b8_m7",  4'd8, -7, 3'b110);

      // b=15 threshold boundaries
      directed("b15_p11", 4'd15,  11, 3'b010);
      directed("b15_p10", 4'd15,  10, 3'b001);
      directed("b15_p3",  4'd15,   3, 3'b001);
      directed("b15_p2",  4'd15,   2, 3'b000);
      directed("b15_m3",  4'd15,  -3, 3'b000);
      directed("b15_m4",  4'd15,  -4, 3'b111);
      directed("b15_m11", 4'd15, -11, 3'b111);
      directed("b15_m12", 4'd15, -12, 3'b110);

      // Extremes and saturation
      directed("b12_p31", 4'd12,  31, 3'b010);
      directed("b12_m32", 4'd12, -32, 3'b110);
      directed("b11_p8",  4'd11,   8, 3'b010);
      directed("b11_p7",  4'd11,   7, 3'b001);

      // Exhaustive sweep, new input every cycle
      for (int bi = 8; bi < 16; bi++) begin
         for (int pi = 0; pi < 64; pi++) begin
            apply(1'b0, 4'(bi), 6'(pi), q);
            obs[bi - 8][pi] = q;
            check("sweep", q, ref_digit(4'(bi), 6'(pi)));
         end
      end

      // Table is symmetric under p -> -p-1 (bitwise complement of p)
      for (int bi = 0; bi < 8; bi++) begin
         for (int pi = 0; pi < 32; pi++) begin
            check("symmetry", obs[bi][pi], 3'(-int'($signed(obs[bi][63 - pi]))));
         end
      end

      // Reset in the middle of a sweep
      for (int pi = 16; pi < 25; pi++) begin
         r = (pi == 20);
         apply(r, 4'd13, 6'(pi), q);
         check(r ? "midsweep_rst" : "midsweep", q, r ? 3'b000 : ref_digit(4'd13, 6'(pi)));
      end

      // Randomised stimulus with occasional reset
      for (int n = 0; n < 400; n++) begin
         r = ($urandom_range(0, 19) == 0);
         b = 4'($urandom_range(8, 15));
         p = 6'($urandom);
         apply(r, b, p, q);
         check("random", q, r ? 3'b000 : ref_digit(b, p));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
